// File: rtl/mul4_fitness_driver.sv
// rtl/mul4_fitness_driver.sv - operand driver, golden shift-add multiplier and fitness scorer for one mul4 individual
module mul4_fitness_driver #(
    parameter int          WORD_W      = 16,
    parameter int          NUM_VECTORS = 256,
    parameter logic [31:0] LFSR_SEED   = 32'hACE11234
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic [WORD_W-1:0]                           dut_a1,
    output logic [WORD_W-1:0]                           dut_a0,
    output logic [WORD_W-1:0]                           dut_b1,
    output logic [WORD_W-1:0]                           dut_b0,
    input  logic [WORD_W-1:0]                           dut_y3,
    input  logic [WORD_W-1:0]                           dut_y2,
    input  logic [WORD_W-1:0]                           dut_y1,
    input  logic [WORD_W-1:0]                           dut_y0,
    output logic [$clog2(NUM_VECTORS*4*WORD_W+1)-1:0]   bit_score,
    output logic [$clog2(NUM_VECTORS+1)-1:0]            exact_count
);
    localparam int AW = 2 * WORD_W;
    localparam int PW = 4 * WORD_W;
    localparam int SW = $clog2(NUM_VECTORS * 4 * WORD_W + 1);
    localparam int EW = $clog2(NUM_VECTORS + 1);
    localparam int MW = $clog2(PW + 1);
    localparam int CW = $clog2(AW);
    localparam logic [31:0]   MASK     = 32'h80200003;
    // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0]   SEED     = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
    localparam logic [EW-1:0] LAST_IDX = EW'(NUM_VECTORS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(AW - 1);
    localparam logic [MW-1:0] FULL     = MW'(PW);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MUL, CMP, FIN} state_t;

    state_t        state;
    logic [31:0]   lfsr;
    logic [31:0]   lfsr_next;
    logic [EW-1:0] idx;
    logic [AW-1:0] op_a;
    logic [AW-1:0] vec_op;
    logic [PW-1:0] mcand;
    logic [AW-1:0] mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [PW-1:0] y;
    logic [MW-1:0] match;

    // Next LFSR state and the operand value for the current vector index
    // (vectors 0 and 1 are fixed corner operands, the rest come from the LFSR).
    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ MASK) : (lfsr >> 1);
        if (idx == '0)
            vec_op = {AW{1'b1}};
        else if (idx == EW'(1))
            vec_op = AW'(1) << WORD_W;
        else
            vec_op = AW'(lfsr_next);
    end

    // Number of result bits that agree with the golden product.
    always_comb begin
        y     = {dut_y3, dut_y2, dut_y1, dut_y0};
        match = '0;
        for (int i = 0; i < PW; i++) begin
            if (y[i] == acc[i])
                match = match + MW'(1);
        end
    end

    // Evaluation sequencer: operand generation, shift-add multiply, scoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= SEED;
            idx         <= '0;
            op_a        <= '0;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dut_a1      <= '0;
            dut_a0      <= '0;
            dut_b1      <= '0;
            dut_b0      <= '0;
            bit_score   <= '0;
            exact_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD_A;
                        busy        <= 1'b1;
                        bit_score   <= '0;
                        exact_count <= '0;
                        idx         <= '0;
                        lfsr        <= SEED;
                    end
                end
                LOAD_A: begin
                    op_a <= vec_op;
                    if (idx >= EW'(2))
                        lfsr <= lfsr_next;
                    state <= LOAD_B;
                end
                LOAD_B: begin
                    {dut_a1, dut_a0} <= op_a;
                    {dut_b1, dut_b0} <= vec_op;
                    mcand  <= PW'(op_a);
                    mplier <= vec_op;
                    acc    <= '0;
                    cnt    <= '0;
                    if (idx >= EW'(2))
                        lfsr <= lfsr_next;
                    state <= MUL;
                end
                MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST_CNT)
                        state <= CMP;
                end
                CMP: begin
                    bit_score <= bit_score + SW'(match);
                    if (match == FULL)
                        exact_count <= exact_count + EW'(1);
                    idx <= idx + EW'(1);
                    state <= (idx == LAST_IDX) ? FIN : LOAD_A;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul4_fitness_driver.sv
// tb/tb_mul4_fitness_driver.sv - self-checking bench for mul4_fitness_driver
module tb_mul4_fitness_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;
    logic [63:0] rand_y = 64'h0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // NUM_VECTORS=4, default seed, y selected by mode
    logic        d4_busy, d4_done;
    logic [15:0] d4_a1, d4_a0, d4_b1, d4_b0;
    logic [63:0] d4_p, d4_y;
    logic [8:0]  d4_bits;
    logic [2:0]  d4_exact;
    assign d4_p = 64'({d4_a1, d4_a0}) * 64'({d4_b1, d4_b0});
    always_comb begin
        case (mode)
            0:       d4_y = d4_p;
            1:       d4_y = 64'h0;
            2:       d4_y = ~d4_p;
            3:       d4_y = d4_p ^ {d4_a1, d4_a0, d4_b1, d4_b0};
            default: d4_y = rand_y;
        endcase
    end
    mul4_fitness_driver #(.WORD_W(16), .NUM_VECTORS(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(d4_busy), .done(d4_done),
        .dut_a1(d4_a1), .dut_a0(d4_a0), .dut_b1(d4_b1), .dut_b0(d4_b0),
        .dut_y3(d4_y[63:48]), .dut_y2(d4_y[47:32]), .dut_y1(d4_y[31:16]), .dut_y0(d4_y[15:0]),
        .bit_score(d4_bits), .exact_count(d4_exact));

    // NUM_VECTORS=2, y tied to zero
    logic        d2_busy, d2_done;
    logic [15:0] d2_a1, d2_a0, d2_b1, d2_b0;
    logic [7:0]  d2_bits;
    logic [1:0]  d2_exact;
    mul4_fitness_driver #(.WORD_W(16), .NUM_VECTORS(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(d2_busy), .done(d2_done),
        .dut_a1(d2_a1), .dut_a0(d2_a0), .dut_b1(d2_b1), .dut_b0(d2_b0),
        .dut_y3(16'h0), .dut_y2(16'h0), .dut_y1(16'h0), .dut_y0(16'h0),
        .bit_score(d2_bits), .exact_count(d2_exact));

    // NUM_VECTORS=8, y = inverted product
    logic        d8_busy, d8_done;
    logic [15:0] d8_a1, d8_a0, d8_b1, d8_b0;
    logic [63:0] d8_y;
    logic [9:0]  d8_bits;
    logic [3:0]  d8_exact;
    assign d8_y = ~(64'({d8_a1, d8_a0}) * 64'({d8_b1, d8_b0}));
    mul4_fitness_driver #(.WORD_W(16), .NUM_VECTORS(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(d8_busy), .done(d8_done),
        .dut_a1(d8_a1), .dut_a0(d8_a0), .dut_b1(d8_b1), .dut_b0(d8_b0),
        .dut_y3(d8_y[63:48]), .dut_y2(d8_y[47:32]), .dut_y1(d8_y[31:16]), .dut_y0(d8_y[15:0]),
        .bit_score(d8_bits), .exact_count(d8_exact));

    // Seed 0 and seed 1 instances, ideal individual
    logic        s0_busy, s0_done, s1_busy, s1_done;
    logic [15:0] s0_a1, s0_a0, s0_b1, s0_b0, s1_a1, s1_a0, s1_b1, s1_b0;
    logic [63:0] s0_y, s1_y;
    logic [8:0]  s0_bits, s1_bits;
    logic [2:0]  s0_exact, s1_exact;
    assign s0_y = 64'({s0_a1, s0_a0}) * 64'({s0_b1, s0_b0});
    assign s1_y = 64'({s1_a1, s1_a0}) * 64'({s1_b1, s1_b0});
    mul4_fitness_driver #(.WORD_W(16), .NUM_VECTORS(4), .LFSR_SEED(32'h0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(s0_busy), .done(s0_done),
        .dut_a1(s0_a1), .dut_a0(s0_a0), .dut_b1(s0_b1), .dut_b0(s0_b0),
        .dut_y3(s0_y[63:48]), .dut_y2(s0_y[47:32]), .dut_y1(s0_y[31:16]), .dut_y0(s0_y[15:0]),
        .bit_score(s0_bits), .exact_count(s0_exact));
    mul4_fitness_driver #(.WORD_W(16), .NUM_VECTORS(4), .LFSR_SEED(32'h1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(s1_busy), .done(s1_done),
        .dut_a1(s1_a1), .dut_a0(s1_a0), .dut_b1(s1_b1), .dut_b0(s1_b0),
        .dut_y3(s1_y[63:48]), .dut_y2(s1_y[47:32]), .dut_y1(s1_y[31:16]), .dut_y0(s1_y[15:0]),
        .bit_score(s1_bits), .exact_count(s1_exact));

    // Captured operands and timing from the most recent run
    logic [31:0] c4_a [4], c4_b [4], cs0_a [4], cs0_b [4], cs1_a [4], cs1_b [4];
    logic [31:0] m_a [8], m_b [8];
    int t4, t2, t8, n4, b4_first;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Reference: operands from the vector rules, golden product by plain multiply.
    task automatic model(input logic [31:0] seed, input int nv, input int md,
                         output int bits, output int exact);
        logic [31:0] s, a, b;
        logic [63:0] g, yy;
        int m;
        s = (seed == 32'h0) ? 32'h1 : seed;
        bits = 0;
        exact = 0;
        for (int v = 0; v < nv; v++) begin
            if (v == 0) begin
                a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
            end else if (v == 1) begin
                a = 32'h0001_0000; b = 32'h0001_0000;
            end else begin
                s = lfsr_step(s); a = s;
                s = lfsr_step(s); b = s;
            end
            if (v < 8) begin m_a[v] = a; m_b[v] = b; end
            g = 64'(a) * 64'(b);
            case (md)
                0:       yy = g;
                1:       yy = 64'h0;
                2:       yy = ~g;
                3:       yy = g ^ {a, b};
                default: yy = rand_y;
            endcase
            m = 64 - $countones(yy ^ g);
            bits += m;
            if (m == 64) exact++;
        end
    endtask

    task automatic run_all(input bit mid_start);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        t4 = -1; t2 = -1; t8 = -1; n4 = 0; b4_first = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (k == 1) b4_first = int'(d4_busy);
            if (d4_done) begin n4++; if (t4 < 0) t4 = k; end
            if (d2_done && t2 < 0) t2 = k;
            if (d8_done && t8 < 0) t8 = k;
            if (k % 35 == 3 && k / 35 < 4) begin
                c4_a[k/35]  = {d4_a1, d4_a0}; c4_b[k/35]  = {d4_b1, d4_b0};
                cs0_a[k/35] = {s0_a1, s0_a0}; cs0_b[k/35] = {s0_b1, s0_b0};
                cs1_a[k/35] = {s1_a1, s1_a0}; cs1_b[k/35] = {s1_b1, s1_b0};
            end
            if (mid_start && (k == 10 || k == 140)) start = 1'b1;
            if (mid_start && (k == 11 || k == 141)) start = 1'b0;
        end
    endtask

    task automatic check_all(input int eb, input int ee);
        int mb, me;
        model(32'hACE11234, 4, mode, mb, me);
        if (eb >= 0) begin mb = eb; me = ee; end
        chk("d4_bit_score", d4_bits, mb);
        chk("d4_exact_count", d4_exact, me);
        chk("d4_done_latency", t4, 141);
        chk("d4_done_width", n4, 1);
        chk("d4_busy_after_start", b4_first, 1);
        chk("d4_busy_end", d4_busy, 0);
        for (int v = 0; v < 4; v++) begin
            chk("d4_operand_a", c4_a[v], m_a[v]);
            chk("d4_operand_b", c4_b[v], m_b[v]);
        end
        chk("d2_bit_score", d2_bits, 95);
        chk("d2_exact_count", d2_exact, 0);
        chk("d2_done_latency", t2, 71);
        chk("d8_bit_score", d8_bits, 0);
        chk("d8_exact_count", d8_exact, 0);
        chk("d8_done_latency", t8, 281);
        model(32'h0, 4, 0, mb, me);
        for (int v = 0; v < 4; v++) begin
            chk("seed0_operand_a", cs0_a[v], m_a[v]);
            chk("seed0_operand_b", cs0_b[v], m_b[v]);
            chk("seed0_vs_seed1_a", cs0_a[v], cs1_a[v]);
            chk("seed0_vs_seed1_b", cs0_b[v], cs1_b[v]);
        end
        chk("seed0_bit_score", s0_bits, 256);
        chk("seed1_exact_count", s1_exact, 4);
    endtask

    typedef struct {
        int mode;
        int exp_bits;
        int exp_exact;
        bit mid_start;
    } vec_t;

    vec_t tbl [5];
    logic [31:0] prev_a [4], prev_b [4];
    int prev_bits, prev_exact;

    initial begin
        tbl[0] = '{0, 256, 4, 1'b0};
        tbl[1] = '{2, 0, 0, 1'b1};
        tbl[2] = '{1, -1, -1, 1'b0};
        tbl[3] = '{3, -1, -1, 1'b0};
        tbl[4] = '{4, -1, -1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", d4_busy, 0);
        chk("reset_done", d4_done, 0);
        chk("reset_bit_score", d4_bits, 0);
        chk("reset_exact_count", d4_exact, 0);
        chk("reset_operands", {d4_a1, d4_a0, d4_b1, d4_b0}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            rand_y = {$urandom, $urandom};
            run_all(tbl[i].mid_start);
            check_all(tbl[i].exp_bits, tbl[i].exp_exact);
        end

        // Back-to-back runs must repeat exactly.
        mode = 3;
        run_all(1'b0);
        check_all(-1, -1);
        for (int v = 0; v < 4; v++) begin prev_a[v] = c4_a[v]; prev_b[v] = c4_b[v]; end
        prev_bits = int'(d4_bits);
        prev_exact = int'(d4_exact);
        run_all(1'b0);
        for (int v = 0; v < 4; v++) begin
            chk("repeat_operand_a", c4_a[v], prev_a[v]);
            chk("repeat_operand_b", c4_b[v], prev_b[v]);
        end
        chk("repeat_bit_score", d4_bits, prev_bits);
        chk("repeat_exact_count", d4_exact, prev_exact);

        // Reset during MUL aborts the evaluation with no done pulse.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", d4_busy, 0);
        chk("abort_done", d4_done, 0);
        chk("abort_bit_score", d4_bits, 0);
        chk("abort_exact_count", d4_exact, 0);
        chk("abort_operands", {d4_a1, d4_a0, d4_b1, d4_b0}, 0);
        chk("abort_d8_bit_score", d8_bits, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n4 = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (d4_done || d8_done) n4++;
        end
        chk("abort_no_done", n4, 0);
        chk("abort_idle_busy", d4_busy, 0);

        run_all(1'b0);
        check_all(256, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
